// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_control codes, the buffered result record and flag-masking helper.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    typedef struct packed {
        logic [3:0]           ctrl;
        logic                 overflow;
        logic                 cout;
        logic                 zero;
        logic [ALU_WIDTH-1:0] result;
    } alu_rec_t;

    // Carry and overflow are only meaningful for the arithmetic operations.
    function automatic logic has_arith_flags(input logic [3:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_buf_ram.sv
// DEPTH x alu_rec_t register array: one synchronous write port, one asynchronous read port.
module alu_buf_ram
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  alu_rec_t      wdata,
    input  logic [AW-1:0] raddr,
    output alu_rec_t      rdata
);

    alu_rec_t mem [DEPTH];

    // NOTE: the array is reset so a stale record can never leak onto the head outputs;
    // this is cheap at this depth and keeps the buffer free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Registered FIFO stage behind the ALU with valid/ready handshake on both sides.
// Define ALU_RESULT_BUFFER_STICKY_EN to enable sticky overflow flag and saturating overflow counter.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_zero,
    input  logic                     in_cout,
    input  logic                     in_overflow,
    input  logic [3:0]               in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_cout,
    output logic                     out_overflow,
    output logic [3:0]               out_ctrl,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clear_sticky,
    output logic                     sticky_ovf,
    output logic [7:0]               ovf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    alu_rec_t      wr_rec;
    alu_rec_t      rd_rec;
    alu_rec_t      head;

    // Both handshakes depend only on registered count, so no ready/valid path crosses the stage.
    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_rec          = '0;
        wr_rec.ctrl     = in_ctrl;
        wr_rec.zero     = in_zero;
        wr_rec.result   = in_result;
        if (has_arith_flags(in_ctrl)) begin
            wr_rec.cout     = in_cout;
            wr_rec.overflow = in_overflow;
        end
    end

    alu_buf_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head         = out_valid ? rd_rec : '0;
    assign out_result   = head.result;
    assign out_zero     = head.zero;
    assign out_cout     = head.cout;
    assign out_overflow = head.overflow;
    assign out_ctrl     = head.ctrl;

`ifdef ALU_RESULT_BUFFER_STICKY_EN
    logic ovf_push;
    assign ovf_push = push && wr_rec.overflow;

    // A new overflow in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= 8'd0;
        end else if (ovf_push) begin
            sticky_ovf <= 1'b1;
            if (clear_sticky)
                ovf_count <= 8'd1;
            else if (ovf_count != 8'hFF)
                ovf_count <= ovf_count + 8'd1;
        end else if (clear_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= 8'd0;
        end
    end
`else
    logic unused_clear_sticky;
    assign unused_clear_sticky = clear_sticky;
    assign sticky_ovf          = 1'b0;
    assign ovf_count           = 8'd0;
`endif

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage directly downstream of the 32-bit combinational `alu`. It captures each ALU result together with its zero/cout/overflow flags and the ALU_control code that produced it. Records are queued in a small FIFO and presented to the consumer (writeback/branch logic) over a valid/ready handshake. This decouples the combinational ALU from a possibly stalling consumer and adds optional sticky overflow tracking.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `WIDTH`, 32, result width; must match the ALU
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  upstream record valid
- `in_ready`  out  1  buffer can accept a record
- `in_result`  in  WIDTH  ALU result
- `in_zero`  in  1  ALU zero flag
- `in_cout`  in  1  ALU carry-out
- `in_overflow`  in  1  ALU overflow
- `in_ctrl`  in  4  ALU_control code of this operation
- `out_valid`  out  1  head record valid
- `out_ready`  in  1  consumer accepts head record
- `out_result`  out  WIDTH  head result
- `out_zero`, `out_cout`, `out_overflow`  out  1 each  head flags
- `out_ctrl`  out  4  head control code
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `clear_sticky`  in  1  clears sticky overflow state
- `sticky_ovf`  out  1  overflow seen since last clear
- `ovf_count`  out  8  number of overflowing pushes, saturating

## Operation
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- `in_ready = (count < DEPTH)`. When full, no push occurs even if a pop happens in the same cycle.
- `out_valid = (count != 0)`. Head fields are driven from the entry at rd_ptr.
- When `out_valid = 0`, all `out_*` data and flag outputs are driven to 0.
- Flag masking at push:
  - `in_cout` and `in_overflow` are stored as given only when `in_ctrl` is ADD (0010) or SUB (0110).
  - For any other code, both are stored as 0.
  - `in_zero` and `in_result` are always stored unmodified.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` updates as: +1 on push only, −1 on pop only, unchanged on push+pop.
- Simultaneous push and pop with 0 < count < DEPTH: both take effect and count is unchanged.
- A pop while empty and a push while full are impossible by construction. They cause no state change.

## Timing
- Reset (async assert, sync deassert handled upstream): pointers, `count`, `sticky_ovf`, `ovf_count` all 0; `out_valid` 0; all `out_*` 0; `in_ready` 1.
- Latency: a record pushed on edge N appears on `out_*` with `out_valid=1` after edge N, usable in cycle N+1. Minimum fall-through latency is 1 cycle. There is no combinational in→out path.
- `in_ready` depends only on registered `count`. There is no combinational path from `out_ready` to `in_ready`.
- Reset asserted mid-operation discards all queued records immediately, without waiting for a clock edge.
- Throughput is one record per cycle sustained, provided the consumer holds `out_ready=1`.

## Configuration
- Macro `ALU_RESULT_BUFFER_STICKY_EN`.
- Defined:
  - On each push whose masked overflow is 1: `sticky_ovf` is set and `ovf_count` increments, saturating at 255.
  - `clear_sticky` zeroes both on the next edge.
  - If a set/increment and `clear_sticky` occur in the same cycle, the set wins: `sticky_ovf=1` and `ovf_count=1`.
- Undefined: `sticky_ovf` and `ovf_count` are constant 0, `clear_sticky` is ignored, and the counter logic is not synthesized. Ports remain present.

## Structure
- Shared package `alu_pkg` contains:
  - ALU_control constants `ALU_AND=0000`, `ALU_OR=0001`, `ALU_ADD=0010`, `ALU_SUB=0110`, `ALU_NOR=1100`, `ALU_NAND=1101`, `ALU_SLT=0111`.
  - A packed record typedef `alu_rec_t` holding {ctrl, overflow, cout, zero, result}.
- One sub-module, `alu_buf_ram`: a DEPTH×`alu_rec_t` register array with one write port and one asynchronous read port. It is reset to 0.
- Pointer, count, handshake and sticky logic live in `alu_result_buffer`.

## Test plan
- Reset then single push: result=0x0000_0005, ctrl=ADD, ovf=0 → next cycle `out_valid=1`, `out_result=5`, `count=1`; pop → `count=0`, `out_*=0`.
- Fill with 4 pushes while `out_ready=0` → `in_ready=0` at count=4. A 5th push is ignored. Drain order is FIFO and the results match the pushed values.
- Push ctrl=AND with `in_overflow=1`, `in_cout=1` → `out_overflow=0`, `out_cout=0`. Push ctrl=SUB with `in_overflow=1` → `out_overflow=1`.
- Steady push+pop every cycle for 10 records at count=2 → count stays 2, no record lost, pointers wrap correctly.
- Assert `rst_n=0` mid-stream at count=3 → `out_valid=0` and `count=0` immediately, before any clock edge. The first record after release is the first one pushed after reset.
- With `ALU_RESULT_BUFFER_STICKY_EN`: 300 overflowing SUB pushes → `ovf_count=255`, `sticky_ovf=1`. Then `clear_sticky` in the same cycle as an overflowing push → `ovf_count=1`, `sticky_ovf=1`.
